// File: rtl/btn_debounce_bank.sv
// Push-button conditioner: two-flop synchroniser plus per-bit counter debouncer with press pulses.
// Optional build macro BTN_RELEASE_EN adds the btn_release pulse port and its registers.
module btn_debounce_bank #(
    parameter int N_BTN     = 12,
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press
`ifdef BTN_RELEASE_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_BTN-1:0] sync1_r;
    logic [N_BTN-1:0] sync2_r;
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_r;
    logic [N_BTN-1:0] press_s;
    logic [CNT_W-1:0] cnt_r [N_BTN];
    logic [CNT_W-1:0] cnt_s [N_BTN];
`ifdef BTN_RELEASE_EN
    logic [N_BTN-1:0] release_r;
    logic [N_BTN-1:0] release_s;
`endif

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Per-bit debounce decision; the >= guard also recovers a counter that was upset past its limit.
    always_comb begin
        level_s = level_r;
        press_s = '0;
`ifdef BTN_RELEASE_EN
        release_s = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            cnt_s[i] = cnt_r[i];
            if (sync2_r[i] == level_r[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] >= CNT_LAST) begin
                cnt_s[i]   = '0;
                level_s[i] = sync2_r[i];
                press_s[i] = sync2_r[i];
`ifdef BTN_RELEASE_EN
                release_s[i] = ~sync2_r[i];
`endif
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounce state and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= '0;
            press_r <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            level_r <= level_s;
            press_r <= press_s;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

`ifdef BTN_RELEASE_EN
    // Release pulse register, only present in the release-enabled build.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            release_r <= '0;
        end else begin
            release_r <= release_s;
        end
    end

    assign btn_release = release_r;
`endif

    assign btn_level = level_r;
    assign btn_press = press_r;

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Input conditioner for the board push-buttons. It synchronises N raw, asynchronous, active-high button inputs to the system clock and debounces each one independently. It drives clean per-button levels and single-cycle press pulses into the button inputs b1..b12 of `full_c_LED`, which lights the four RGB LEDs. It sits directly between the top-level pads and that block, with bit 0 mapping to b1 and bit 11 to b12.

## Interface
Parameters:
- N_BTN, 12: number of buttons, at least 1.
- DB_CYCLES, 250000: consecutive stable samples required before a level change is accepted (10 ms at 25 MHz); at least 1.
- CNT_W, $clog2(DB_CYCLES+1): width of each per-button counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- btn_raw  in  N_BTN  raw pad inputs, asynchronous, 1 = pressed.
- btn_level  out  N_BTN  debounced level, registered, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on each accepted 0->1 transition.
- btn_release  out  N_BTN  one-cycle pulse on each accepted 1->0 transition; present only with BTN_RELEASE_EN.

## Operation
Each bit i runs the following logic independently; there is no cross-bit interaction.
- Synchroniser: two flops, btn_raw[i] -> s1 -> s2. Only s2 is used downstream.
- Counter cnt, CNT_W bits, counts consecutive edges on which s2 != btn_level[i]. Each rising edge applies exactly one of:
  - s2 == btn_level[i]: cnt <= 0. Any partial count is discarded.
  - s2 != btn_level[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s2 != btn_level[i] and cnt == DB_CYCLES-1: btn_level[i] <= s2, cnt <= 0, btn_press[i] <= s2, btn_release[i] <= ~s2.
- On every other edge, btn_press[i] <= 0 and btn_release[i] <= 0. The pulse outputs are registered, never combinational.
- Counter arithmetic: cnt never exceeds DB_CYCLES-1 and never wraps.
- The block holds no FSM beyond the per-bit level bit plus counter. Effective states per bit are STABLE (cnt == 0) and PENDING (cnt > 0).
- Glitch rejection:
  - A disagreement lasting fewer than DB_CYCLES samples never changes btn_level.
  - A bounce that returns to the old level resets cnt to 0.
- Simultaneous events:
  - Any number of bits may pulse on the same cycle.
  - The press of one bit and the release of another may coincide.

## Timing
- Reset, on rst_n low, immediately and regardless of clk:
  - s1, s2, cnt, btn_level, btn_press and btn_release all go to 0.
  - A button held pressed through reset is then accepted as a press DB_CYCLES+2 edges after rst_n rises.
- Latency: if btn_raw[i] changes before edge 1 and stays stable, then:
  - s1 updates on edge 1 and s2 on edge 2.
  - btn_level[i] and the pulse register update on edge DB_CYCLES+2.
  - The pulse is high for exactly one clock period after that edge.
- Minimum accepted pulse width: DB_CYCLES clocks of stable s2.
- Reset mid-count: asserting rst_n clears any PENDING count. After release, counting restarts from 0.
- Back-to-back toggles: the next opposite transition needs a fresh DB_CYCLES samples. Each accepted transition therefore yields exactly one pulse.
- btn_raw bits that change within the same cycle are not required to be accepted on the same cycle, because metastability resolution can differ by one cycle.

## Configuration
- BTN_RELEASE_EN defined:
  - The btn_release port and its registers exist, with behaviour as above.
- BTN_RELEASE_EN undefined:
  - The btn_release port is absent and no release logic is synthesised.
  - btn_level and btn_press behave identically in both builds.

## Test plan
All scenarios use DB_CYCLES=4 and N_BTN=12.
- Reset:
  - Stimulus: rst_n low with btn_raw=12'hFFF.
  - Required: all outputs 0.
  - Stimulus: release rst_n and hold btn_raw.
  - Required: btn_level=12'hFFF after edge 6, btn_press=12'hFFF for one cycle only.
- Clean press and release on bit 0:
  - Stimulus: raise btn_raw[0].
  - Required: btn_level[0]=1 after edge 6 and a single btn_press[0] pulse.
  - Stimulus: drop btn_raw[0] 20 cycles later.
  - Required: btn_level[0]=0 six edges later, with a btn_release[0] pulse when BTN_RELEASE_EN is defined.
- Glitch rejection on bit 3:
  - Stimulus: btn_raw[3] high for 3 cycles, then low.
  - Required: btn_level[3] stays 0 and no pulse on btn_press or btn_release.
- Bounce on bit 5:
  - Stimulus: btn_raw[5] pattern 1,0,1,1,0,1 then held 1.
  - Required: exactly one btn_press[5] pulse, 6 edges after the final rise.
- Simultaneous events:
  - Stimulus: bits 1 and 11 pressed on the same cycle while bit 7, previously pressed, is released.
  - Required: btn_press=12'h802 on a single cycle, btn_release=12'h080 when enabled, btn_level updated on the same edge.
- Reset mid-count:
  - Stimulus: btn_raw[2] high; assert rst_n after edge 4 for 1 cycle, keep btn_raw[2] high.
  - Required: no pulse before reset; btn_press[2] pulses 6 edges after rst_n deasserts.
